mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single unified memory port between the fetch stage (instruction reads) and the memory stage (loads/stores) of the pipelined core.
- Grants one outstanding transaction at a time, data priority, with a bounded-starvation guarantee for fetch.
- Generates per-requester stall signals that feed the pipeline enables alongside the load-use hazard stall.
- Supports fetch flush on a taken branch/jump.

Parameters:
- AW, 32, address width
- DW, 32, data width
- STARVE_MAX, 4, consecutive data grants allowed while fetch waits; on reaching it, fetch wins the next arbitration

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- i_req  in  1  fetch request, held until i_done or i_flush
- i_addr  in  AW  fetch address, stable while i_req high
- i_flush  in  1  cancel the current/pending fetch (branch taken)
- i_rdata  out  DW  fetch data, valid when i_done
- i_done  out  1  fetch complete, one-cycle pulse
- d_req  in  1  data request, held until d_done
- d_we  in  1  1 = store
- d_be  in  DW/8  byte enables for a store
- d_addr  in  AW  data address
- d_wdata  in  DW  store data
- d_rdata  out  DW  load data, valid when d_done
- d_done  out  1  data complete, one-cycle pulse
- mem_req  out  1  memory request
- mem_we  out  1  memory write enable
- mem_be  out  DW/8  memory byte enables
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid with mem_ack
- mem_ack  in  1  memory completion, one cycle per request
- stall_i  out  1  fetch must hold (drives PC/F enables low)
- stall_d  out  1  memory stage must hold (drives pipeline enables low)

Behaviour:
- States: IDLE, I_BUSY, D_BUSY, I_DRAIN. Reset and async rst assertion force IDLE.
- Reset values: all mem_* outputs 0; done 0; starve counter 0.
- Reset mid-transaction abandons the access. The memory must tolerate mem_req dropping without ack.
- Arbitration happens in IDLE, and at the ack edge of any busy state, so back-to-back grants are possible:
  - Default: d_req wins over i_req.
  - If starve_cnt == STARVE_MAX and i_req && !i_flush, fetch wins.
- Grant is registered. A request seen at edge N gives state BUSY and mem_req=1 in cycle N+1.
- mem_* fields are registered at grant and remain stable until mem_ack. Fetch grants drive mem_we=0 and mem_be=all-ones.
- Completion: i_done / d_done = mem_ack in the matching busy state, combinational. i_rdata / d_rdata = mem_rdata pass-through.
- Minimum latency, request to done: 2 cycles with a zero-wait memory (ack in the first mem_req cycle).
- A requester's req still high in the cycle after done counts as a new request.
- stall_i = i_req & ~i_done & ~i_flush.
- stall_d = d_req & ~d_done.
- Starve counter:
  - Increments on each data grant while i_req is high.
  - Clears on a fetch grant, or whenever i_req is low.
  - Saturates at STARVE_MAX.
- Fetch flush:
  - i_flush in IDLE, or in the same cycle as an i_req arbitration: no fetch grant that cycle.
  - i_flush in I_BUSY without mem_ack: go to I_DRAIN. The memory access completes but i_done stays suppressed. On mem_ack in I_DRAIN, re-arbitrate.
  - i_flush in I_BUSY together with mem_ack: i_done suppressed, re-arbitrate normally.
- Simultaneous d_req and i_req in IDLE: data granted, fetch stalls.
- Fetch starvation is bounded by STARVE_MAX data transactions.
- i_flush has no effect on data transactions.

Decomposition:
- Shared package rv_mem_pkg holds:
  - arb_state_t enum (IDLE, I_BUSY, D_BUSY, I_DRAIN)
  - mem_req_t struct {we, be, addr, wdata}, reused by the cache/memory models
- One natural sub-module: starve_counter (saturating counter with clear/inc/sat flag).
- The FSM and muxes stay in the top module.

Test Plan:
- Zero-wait memory; i_req with i_addr=0x100; mem_rdata=0x00500093 -> mem_req in cycle 1, mem_ack in cycle 1, i_done + i_rdata=0x00500093 in cycle 1. stall_i=1 in cycle 0 only.
- i_req and d_req both asserted in cycle 0; d_we=1, d_addr=0x2000, d_wdata=0xDEADBEEF, d_be=4'b1111 -> store issued first. Fetch is granted on the ack edge (back-to-back). stall_i stays high until the fetch ack.
- d_req held continuously for 6 transactions while i_req stays high, STARVE_MAX=4 -> 4 data grants, then 1 fetch grant, then data resumes.
- 3-cycle memory latency; i_flush pulsed in the 2nd I_BUSY cycle -> state I_DRAIN. mem_req stays high until ack, no i_done pulse, next d_req granted on the ack edge.
- Load to d_addr=0x40 with mem_rdata=0x12345678 after 2 waits -> d_done is a single pulse with d_rdata=0x12345678. stall_d=1 for exactly 3 cycles.
- rst asserted asynchronously mid D_BUSY -> mem_req, d_done and stall outputs go to 0 immediately. After release, a new i_req is granted from IDLE.

Source files
------------

// File: rtl/rv_mem_pkg.sv
// Shared memory-port types: arbiter state encoding and the request record
// that the cache and memory models also use.
package rv_mem_pkg;

  localparam int MEM_AW = 32;
  localparam int MEM_DW = 32;
  localparam int MEM_BW = MEM_DW / 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    I_BUSY  = 2'd1,
    D_BUSY  = 2'd2,
    I_DRAIN = 2'd3
  } arb_state_t;

  typedef struct packed {
    logic              we;
    logic [MEM_BW-1:0] be;
    logic [MEM_AW-1:0] addr;
    logic [MEM_DW-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/mem_port_arbiter_starve_counter.sv
// Saturating count of data grants issued while fetch is waiting.
// Clear has priority over increment; sat is high once the count reaches MAX.
module starve_counter #(
  parameter int MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic sat
);

  localparam int CW = $clog2(MAX + 1);

  logic [CW-1:0] cnt_q;

  // Counter register: clear wins, increment stops at MAX.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != CW'(MAX))) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign sat = (cnt_q == CW'(MAX));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between instruction fetch and the
// memory stage. Data has priority; fetch wins after STARVE_MAX data grants
// in a row while it waits.
//
// Handshake: a requester raises *_req and holds it (with stable fields) until
// its *_done pulse; if req is still high when done pulses, that is taken as
// the next request. Toward memory, mem_req stays high with stable fields
// until the single mem_ack cycle; mem_ack is only honoured while mem_req is high.
module mem_port_arbiter
  import rv_mem_pkg::*;
#(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_req,
  input  logic [AW-1:0]   i_addr,
  input  logic            i_flush,
  output logic [DW-1:0]   i_rdata,
  output logic            i_done,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [DW/8-1:0] d_be,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  output logic [DW-1:0]   d_rdata,
  output logic            d_done,
  output logic            mem_req,
  output logic            mem_we,
  output logic [DW/8-1:0] mem_be,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic [DW-1:0]   mem_rdata,
  input  logic            mem_ack,
  output logic            stall_i,
  output logic            stall_d,
  output arb_state_t      dbg_state
);

  arb_state_t state_q, state_d;
  mem_req_t   mem_q;
  logic       arb, grant_i, grant_d, starve_sat;

  // Next-state and grant decision; arbitration runs in IDLE and on any ack.
  always_comb begin
    state_d = state_q;
    arb     = (state_q == IDLE) || mem_ack;
    grant_i = arb && i_req && !i_flush && (!d_req || starve_sat);
    grant_d = arb && d_req && !grant_i;
    if (arb) begin
      if (grant_d)      state_d = D_BUSY;
      else if (grant_i) state_d = I_BUSY;
      else              state_d = IDLE;
    end else if ((state_q == I_BUSY) && i_flush) begin
      // The access already on the bus must finish; its data is discarded.
      state_d = I_DRAIN;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Request fields are captured at grant and held through the ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '0;
    end else if (grant_d) begin
      mem_q.we    <= d_we;
      mem_q.be    <= MEM_BW'(d_be);
      mem_q.addr  <= MEM_AW'(d_addr);
      mem_q.wdata <= MEM_DW'(d_wdata);
    end else if (grant_i) begin
      mem_q.we    <= 1'b0;
      mem_q.be    <= '1;
      mem_q.addr  <= MEM_AW'(i_addr);
      mem_q.wdata <= '0;
    end
  end

  starve_counter #(.MAX(STARVE_MAX)) u_starve (
    .clk (clk),
    .rst (rst),
    .clr (grant_i || !i_req),
    .inc (grant_d && i_req),
    .sat (starve_sat)
  );

  assign mem_req   = (state_q != IDLE);
  assign mem_we    = mem_q.we;
  assign mem_be    = mem_q.be[DW/8-1:0];
  assign mem_addr  = mem_q.addr[AW-1:0];
  assign mem_wdata = mem_q.wdata[DW-1:0];

  assign i_done  = mem_ack && (state_q == I_BUSY) && !i_flush;
  assign d_done  = mem_ack && (state_q == D_BUSY);
  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;

  // Stalls drop immediately on reset so the pipeline is released at once.
  assign stall_i = i_req && !i_done && !i_flush && !rst;
  assign stall_d = d_req && !d_done && !rst;

  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a per-cycle vector table for the
// main flows plus hand-written flush and async-reset sequences.
module tb_mem_port_arbiter;
  import rv_mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, i_flush, i_done;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_we, d_done;
  logic [3:0]  d_be;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        mem_req, mem_we, mem_ack;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        stall_i, stall_d;
  arb_state_t  dbg_state;

  int checks = 0;
  int errors = 0;
  logic [1:0] exp_q[$];

  typedef struct {
    logic        ireq, iflush, dreq, dwe, ack;
    logic [31:0] daddr, dwdata, rdata;
    arb_state_t  xst;
    logic        xmreq, xwe;
    logic [31:0] xaddr, xwdata;
    logic        xidone, xddone, xstalli, xstalld;
  } vec_t;

  vec_t vecs[22];

  mem_port_arbiter #(.AW(32), .DW(32), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_flush(i_flush),
    .i_rdata(i_rdata), .i_done(i_done),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_rdata(d_rdata), .d_done(d_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .stall_i(stall_i), .stall_d(stall_d), .dbg_state(dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    i_req = 0; i_flush = 0; i_addr = 32'h100;
    d_req = 0; d_we = 0; d_be = 4'hF; d_addr = 0; d_wdata = 0;
    mem_ack = 0; mem_rdata = 0;
  endtask

  task automatic apply_vec(input vec_t v);
    i_req = v.ireq; i_flush = v.iflush;
    d_req = v.dreq; d_we = v.dwe; d_addr = v.daddr; d_wdata = v.dwdata;
    mem_ack = v.ack; mem_rdata = v.rdata;
  endtask

  task automatic check_vec(input int n, input vec_t v);
    chk($sformatf("v%0d state", n), 32'(dbg_state), 32'(v.xst));
    chk($sformatf("v%0d mem_req", n), 32'(mem_req), 32'(v.xmreq));
    chk($sformatf("v%0d i_done", n), 32'(i_done), 32'(v.xidone));
    chk($sformatf("v%0d d_done", n), 32'(d_done), 32'(v.xddone));
    chk($sformatf("v%0d stall_i", n), 32'(stall_i), 32'(v.xstalli));
    chk($sformatf("v%0d stall_d", n), 32'(stall_d), 32'(v.xstalld));
    if (v.xmreq) begin
      chk($sformatf("v%0d mem_we", n), 32'(mem_we), 32'(v.xwe));
      chk($sformatf("v%0d mem_addr", n), mem_addr, v.xaddr);
      chk($sformatf("v%0d mem_wdata", n), mem_wdata, v.xwdata);
    end
    if (v.xidone) chk($sformatf("v%0d i_rdata", n), i_rdata, v.rdata);
    if (v.xddone) chk($sformatf("v%0d d_rdata", n), d_rdata, v.rdata);
  endtask

  initial begin
    // Zero-wait fetch; held i_req re-requests; flush coinciding with ack.
    vecs[0]  = '{1,0,0,0,0, 0,0,0,                       IDLE,  0,0,0,0,                       0,0,1,0};
    vecs[1]  = '{1,0,0,0,1, 0,0,32'h00500093,            I_BUSY,1,0,32'h100,0,                 1,0,0,0};
    vecs[2]  = '{0,1,0,0,1, 0,0,32'h11111111,            I_BUSY,1,0,32'h100,0,                 0,0,0,0};
    vecs[3]  = '{0,0,0,0,0, 0,0,0,                       IDLE,  0,0,0,0,                       0,0,0,0};
    // Store and fetch together: store first, fetch on the ack edge.
    vecs[4]  = '{1,0,1,1,0, 32'h2000,32'hDEADBEEF,0,     IDLE,  0,0,0,0,                       0,0,1,1};
    vecs[5]  = '{1,0,0,1,1, 32'h2000,32'hDEADBEEF,0,     D_BUSY,1,1,32'h2000,32'hDEADBEEF,     0,1,1,0};
    vecs[6]  = '{0,0,0,0,1, 0,0,32'h0BADF00D,            I_BUSY,1,0,32'h100,0,                 1,0,0,0};
    vecs[7]  = '{0,0,0,0,0, 0,0,0,                       IDLE,  0,0,0,0,                       0,0,0,0};
    // Both held: four data grants, one fetch, then data resumes.
    vecs[8]  = '{1,0,1,0,0, 32'h300,0,0,                 IDLE,  0,0,0,0,                       0,0,1,1};
    vecs[9]  = '{1,0,1,0,1, 32'h300,0,32'hA1,            D_BUSY,1,0,32'h300,0,                 0,1,1,0};
    vecs[10] = '{1,0,1,0,1, 32'h300,0,32'hA2,            D_BUSY,1,0,32'h300,0,                 0,1,1,0};
    vecs[11] = '{1,0,1,0,1, 32'h300,0,32'hA3,            D_BUSY,1,0,32'h300,0,                 0,1,1,0};
    vecs[12] = '{1,0,1,0,1, 32'h300,0,32'hA4,            D_BUSY,1,0,32'h300,0,                 0,1,1,0};
    vecs[13] = '{1,0,1,0,1, 32'h300,0,32'hB5,            I_BUSY,1,0,32'h100,0,                 1,0,0,1};
    vecs[14] = '{0,0,1,0,1, 32'h300,0,32'hA6,            D_BUSY,1,0,32'h300,0,                 0,1,0,0};
    vecs[15] = '{0,0,0,0,1, 32'h300,0,32'hA7,            D_BUSY,1,0,32'h300,0,                 0,1,0,0};
    vecs[16] = '{0,0,0,0,0, 0,0,0,                       IDLE,  0,0,0,0,                       0,0,0,0};
    // Load with two wait cycles.
    vecs[17] = '{0,0,1,0,0, 32'h40,0,0,                  IDLE,  0,0,0,0,                       0,0,0,1};
    vecs[18] = '{0,0,1,0,0, 32'h40,0,0,                  D_BUSY,1,0,32'h40,0,                  0,0,0,1};
    vecs[19] = '{0,0,1,0,0, 32'h40,0,0,                  D_BUSY,1,0,32'h40,0,                  0,0,0,1};
    vecs[20] = '{0,0,0,0,1, 32'h40,0,32'h12345678,       D_BUSY,1,0,32'h40,0,                  0,1,0,0};
    vecs[21] = '{0,0,0,0,0, 0,0,0,                       IDLE,  0,0,0,0,                       0,0,0,0};

    // Reset values
    drive_idle();
    rst = 1'b1;
    #2;
    chk("rst state", 32'(dbg_state), 32'(IDLE));
    chk("rst mem_req", 32'(mem_req), 0);
    chk("rst mem_we", 32'(mem_we), 0);
    chk("rst mem_be", 32'(mem_be), 0);
    chk("rst mem_addr", mem_addr, 0);
    chk("rst mem_wdata", mem_wdata, 0);
    chk("rst i_done", 32'(i_done), 0);
    chk("rst d_done", 32'(d_done), 0);
    @(negedge clk);
    rst = 1'b0;

    // Table
    for (int n = 0; n < 22; n++) begin
      @(negedge clk);
      apply_vec(vecs[n]);
      #1;
      check_vec(n, vecs[n]);
    end

    // Flush in the 2nd I_BUSY cycle of a 3-cycle access, then data on the ack edge.
    exp_q.push_back(2'(IDLE));    exp_q.push_back(2'(I_BUSY));
    exp_q.push_back(2'(I_BUSY));  exp_q.push_back(2'(I_DRAIN));
    exp_q.push_back(2'(D_BUSY));  exp_q.push_back(2'(IDLE));
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      drive_idle();
      case (c)
        0: i_req = 1;
        1: i_req = 1;
        2: i_flush = 1;
        3: begin d_req = 1; d_we = 1; d_addr = 32'h500; d_wdata = 32'hCAFEF00D; mem_ack = 1; end
        4: begin d_we = 1; d_addr = 32'h500; d_wdata = 32'hCAFEF00D; mem_ack = 1; end
        default: ;
      endcase
      #1;
      chk($sformatf("fl%0d state", c), 32'(dbg_state), 32'(exp_q.pop_front()));
      chk($sformatf("fl%0d i_done", c), 32'(i_done), 0);
      chk($sformatf("fl%0d mem_req", c), 32'(mem_req), 32'((c >= 1) && (c <= 4)));
      if (c == 3) chk("fl3 drain addr", mem_addr, 32'h100);
      if (c == 4) begin
        chk("fl4 addr", mem_addr, 32'h500);
        chk("fl4 we", 32'(mem_we), 1);
        chk("fl4 wdata", mem_wdata, 32'hCAFEF00D);
        chk("fl4 be", 32'(mem_be), 32'hF);
        chk("fl4 d_done", 32'(d_done), 1);
      end
    end

    // Async reset in the middle of a data access.
    @(negedge clk);
    drive_idle();
    i_req = 1; d_req = 1; d_addr = 32'h80;
    #1 chk("ar stall_d", 32'(stall_d), 1);
    @(negedge clk);
    mem_ack = 1;
    #1;
    chk("ar busy", 32'(dbg_state), 32'(D_BUSY));
    chk("ar d_done pre", 32'(d_done), 1);
    #1 rst = 1'b1;
    #1;
    chk("ar state", 32'(dbg_state), 32'(IDLE));
    chk("ar mem_req", 32'(mem_req), 0);
    chk("ar d_done", 32'(d_done), 0);
    chk("ar stall_d 0", 32'(stall_d), 0);
    chk("ar stall_i 0", 32'(stall_i), 0);
    chk("ar mem_addr", mem_addr, 0);
    @(negedge clk);
    rst = 1'b0; mem_ack = 0; d_req = 0; i_req = 1;
    #1 chk("ar2 stall_i", 32'(stall_i), 1);
    @(negedge clk);
    #1;
    chk("ar3 state", 32'(dbg_state), 32'(I_BUSY));
    chk("ar3 mem_req", 32'(mem_req), 1);
    chk("ar3 addr", mem_addr, 32'h100);
    chk("ar3 we", 32'(mem_we), 0);
    chk("ar3 be", 32'(mem_be), 32'hF);
    @(negedge clk);
    i_req = 0; mem_ack = 1; mem_rdata = 32'h55AA55AA;
    #1;
    chk("ar4 i_done", 32'(i_done), 1);
    chk("ar4 i_rdata", i_rdata, 32'h55AA55AA);
    @(negedge clk);
    drive_idle();
    #1 chk("ar5 state", 32'(dbg_state), 32'(IDLE));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
